// File: rtl/stream_demux2.sv
// Two-way stream demultiplexer: each input word is steered by in_sel into one
// of two independent 2-entry FIFOs, each drained by its own valid/ready consumer.

module stream_demux2_fifo #(
  parameter int unsigned width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] wdata,
  output logic             full,
  output logic             valid,
  output logic [width-1:0] rdata,
  output logic [1:0]       count
);

  localparam int unsigned cnt_w = 2;
  localparam logic [cnt_w-1:0] depth = cnt_w'(2);

  logic             wptr;
  logic             rptr;
  logic [width-1:0] mem [2];
  logic             do_push;
  logic             do_pop;
  logic [cnt_w-1:0] count_nxt;

  // A full FIFO refuses a push even when it pops in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & valid;

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + cnt_w'(1);
      2'b01:   count_nxt = count - cnt_w'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= '0;
    end else begin
      if (do_push) wptr <= ~wptr;
      if (do_pop)  rptr <= ~rptr;
      count <= count_nxt;
    end
  end

  // Storage is deliberately left unreset; contents only matter while valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  assign full  = (count == depth);
  assign valid = (count != '0);
  assign rdata = mem[rptr];

endmodule

module stream_demux2 #(
  parameter int unsigned width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [width-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [width-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [width-1:0] out1_data,
  output logic [1:0]       count0,
  output logic [1:0]       count1
);

  logic full0;
  logic full1;
  logic push0;
  logic push1;

  // Ready depends only on the selected channel's registered occupancy.
  assign in_ready = in_sel ? ~full1 : ~full0;
  assign push0    = in_valid & ~in_sel;
  assign push1    = in_valid &  in_sel;

  stream_demux2_fifo #(.width(width)) u_ch0 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push0),
    .pop   (out0_ready),
    .wdata (in_data),
    .full  (full0),
    .valid (out0_valid),
    .rdata (out0_data),
    .count (count0)
  );

  stream_demux2_fifo #(.width(width)) u_ch1 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push1),
    .pop   (out1_ready),
    .wdata (in_data),
    .full  (full1),
    .valid (out1_valid),
    .rdata (out1_data),
    .count (count1)
  );

endmodule

// File: tb/tb_stream_demux2.sv
// Bench for stream_demux2: directed vector table, async reset sequence and a
// random interleave, all checked against per-channel reference queues.

module tb_stream_demux2;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sel;
  logic [15:0] in_data;
  logic        out0_valid;
  logic        out0_ready;
  logic [15:0] out0_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [15:0] out1_data;
  logic [1:0]  count0;
  logic [1:0]  count1;

  int passed;
  int total;
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  stream_demux2 #(.width(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .count0     (count0),
    .count1     (count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        sel;
    logic [15:0] d;
    logic        r0;
    logic        r1;
    logic        exp_ir;
    logic [1:0]  c0;
    logic [1:0]  c1;
    logic [15:0] d0;
    logic [15:0] d1;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  // Drive one cycle, check against the reference queues, advance the model.
  task automatic cycle(input logic iv, input logic sel, input logic [15:0] d,
                       input logic r0, input logic r1, output logic ir_seen);
    logic ir_exp;
    in_valid = iv; in_sel = sel; in_data = d; out0_ready = r0; out1_ready = r1;
    #1;
    ir_seen = in_ready;
    ir_exp  = sel ? (q1.size() < 2) : (q0.size() < 2);
    chk("in_ready", 32'(in_ready), 32'(ir_exp));
    chk("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
    chk("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
    if (q0.size() != 0) chk("out0_data", 32'(out0_data), 32'(q0[0]));
    if (q1.size() != 0) chk("out1_data", 32'(out1_data), 32'(q1[0]));
    chk("count0", 32'(count0), 32'(q0.size()));
    chk("count1", 32'(count1), 32'(q1.size()));
    chk("count0_le2", 32'(count0 <= 2'd2), 32'd1);
    chk("count1_le2", 32'(count1 <= 2'd2), 32'd1);
    if (r0 && q0.size() != 0) void'(q0.pop_front());
    if (r1 && q1.size() != 0) void'(q1.pop_front());
    if (iv && ir_exp) begin
      if (sel) q1.push_back(d);
      else     q0.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic ir;
    passed = 0;
    total  = 0;
    //          iv  sel  d         r0  r1  ir  c0  c1  d0        d1
    tbl[0]  = '{1, 0, 16'h1234, 0, 0, 1, 1, 0, 16'h1234, 16'h0000};
    tbl[1]  = '{1, 0, 16'h0002, 1, 0, 1, 1, 0, 16'h0002, 16'h0000};
    tbl[2]  = '{1, 1, 16'hAAAA, 0, 0, 1, 1, 1, 16'h0002, 16'hAAAA};
    tbl[3]  = '{1, 1, 16'hBBBB, 0, 0, 1, 1, 2, 16'h0002, 16'hAAAA};
    tbl[4]  = '{1, 1, 16'hCCCC, 0, 0, 0, 1, 2, 16'h0002, 16'hAAAA};
    tbl[5]  = '{0, 0, 16'h0000, 0, 0, 1, 1, 2, 16'h0002, 16'hAAAA};
    tbl[6]  = '{1, 0, 16'h0003, 0, 0, 1, 2, 2, 16'h0002, 16'hAAAA};
    tbl[7]  = '{1, 0, 16'h0004, 1, 0, 0, 1, 2, 16'h0003, 16'hAAAA};
    tbl[8]  = '{1, 1, 16'hCCCC, 0, 1, 0, 1, 1, 16'h0003, 16'hBBBB};
    tbl[9]  = '{1, 1, 16'hCCCC, 0, 1, 1, 1, 1, 16'h0003, 16'hCCCC};
    tbl[10] = '{0, 0, 16'h0000, 1, 1, 1, 0, 0, 16'h0000, 16'h0000};
    tbl[11] = '{0, 0, 16'h0000, 1, 1, 1, 0, 0, 16'h0000, 16'h0000};
    tbl[12] = '{1, 1, 16'h00AA, 1, 1, 1, 0, 1, 16'h0000, 16'h00AA};

    rst_n = 1'b0;
    in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    #12;
    chk("rst_count0", 32'(count0), 32'd0);
    chk("rst_count1", 32'(count1), 32'd0);
    chk("rst_out0_valid", 32'(out0_valid), 32'd0);
    chk("rst_out1_valid", 32'(out1_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].iv, tbl[i].sel, tbl[i].d, tbl[i].r0, tbl[i].r1, ir);
      chk($sformatf("vec%0d_in_ready", i), 32'(ir), 32'(tbl[i].exp_ir));
      chk($sformatf("vec%0d_count0", i), 32'(count0), 32'(tbl[i].c0));
      chk($sformatf("vec%0d_count1", i), 32'(count1), 32'(tbl[i].c1));
      chk($sformatf("vec%0d_out0_valid", i), 32'(out0_valid), 32'(tbl[i].c0 != 0));
      chk($sformatf("vec%0d_out1_valid", i), 32'(out1_valid), 32'(tbl[i].c1 != 0));
      if (tbl[i].c0 != 0) chk($sformatf("vec%0d_out0_data", i), 32'(out0_data), 32'(tbl[i].d0));
      if (tbl[i].c1 != 0) chk($sformatf("vec%0d_out1_data", i), 32'(out1_data), 32'(tbl[i].d1));
    end

    // Async reset between edges with both channels occupied.
    cycle(1'b1, 1'b0, 16'h0101, 1'b0, 1'b0, ir);
    cycle(1'b1, 1'b0, 16'h0202, 1'b0, 1'b0, ir);
    chk("pre_rst_count0", 32'(count0), 32'd2);
    chk("pre_rst_count1", 32'(count1), 32'd1);
    in_valid = 1'b0; in_sel = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count0", 32'(count0), 32'd0);
    chk("mid_rst_count1", 32'(count1), 32'd0);
    chk("mid_rst_out0_valid", 32'(out0_valid), 32'd0);
    chk("mid_rst_out1_valid", 32'(out1_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    q0.delete();
    q1.delete();
    in_valid = 1'b1; in_sel = 1'b1; in_data = 16'hDEAD;
    @(posedge clk);
    #1;
    chk("rst_edge_count1", 32'(count1), 32'd0);
    chk("rst_edge_out1_valid", 32'(out1_valid), 32'd0);
    rst_n = 1'b1;
    cycle(1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, ir);
    chk("post_rst_out1_valid", 32'(out1_valid), 32'd1);
    chk("post_rst_out1_data", 32'(out1_data), 32'h5555);
    chk("post_rst_count1", 32'(count1), 32'd1);

    for (int n = 0; n < 10000; n++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ir);
    end
    for (int n = 0; n < 4; n++) cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, ir);
    chk("drain_count0", 32'(count0), 32'd0);
    chk("drain_count1", 32'(count1), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
